// File: rtl/dds_pkg.sv
// Shared types and constants for the DDS command arbiter.
package dds_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_HI = 2'd1,
    WAIT_LO = 2'd2,
    ACK     = 2'd3
  } dds_state_e;

  typedef enum logic [1:0] {
    ID_UPDATE = 2'd0,
    ID_CONFIG = 2'd1,
    ID_SWEEP  = 2'd2
  } req_id_e;

  localparam logic [31:0] STEP_FAST = 32'h00221b26;
  localparam logic [31:0] STEP_SLOW = 32'h0006d23a;

endpackage

// File: rtl/dds_cmd_arbiter_prio_enc.sv
// Combinational fixed-priority encoder: sweep > config > update.
module dds_prio_enc
  import dds_pkg::*;
(
  input  logic    req_sweep,
  input  logic    req_config,
  input  logic    req_update,
  output req_id_e gnt_id,
  output logic    gnt_vld
);

  // Highest-priority active request wins.
  always_comb begin
    gnt_id  = ID_UPDATE;
    gnt_vld = 1'b0;
    if (req_sweep) begin
      gnt_id  = ID_SWEEP;
      gnt_vld = 1'b1;
    end else if (req_config) begin
      gnt_id  = ID_CONFIG;
      gnt_vld = 1'b1;
    end else if (req_update) begin
      gnt_id  = ID_UPDATE;
      gnt_vld = 1'b1;
    end
  end

endmodule

// File: rtl/dds_cmd_arbiter.sv
// Arbitrates three requesters onto one AD9914 driver command port and runs
// the strobe/busy handshake, with an abort if the driver never answers.
//
// state   | meaning
// IDLE    | waiting for a request while the driver is idle
// WAIT_HI | strobe held, waiting for driver busy to rise
// WAIT_LO | strobe dropped, waiting for driver busy to fall
// ACK     | one-cycle ack to the granted requester
module dds_cmd_arbiter
  import dds_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] STEP_RESET     = STEP_FAST
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_update,
  input  logic        req_config,
  input  logic [31:0] cfg_step,
  input  logic        req_sweep,
  output logic        ack_update,
  output logic        ack_config,
  output logic        ack_sweep,
  output logic        dds_update,
  output logic        dds_update_config,
  output logic        dds_sweep,
  output logic [31:0] dds_sweep_step,
  input  logic        dds_busy,
  output logic        arb_busy,
  output logic        timeout_err,
  input  logic        clr_err
);

  // Counter value on which a wait state gives up.
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  dds_state_e  state_q, state_d;
  req_id_e     id_q, id_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] step_q, step_d;
  logic        err_q, err_d;
  logic        upd_q, upd_d;
  logic        cfg_q, cfg_d;
  logic        swp_q, swp_d;
  logic        ack_u_q, ack_u_d;
  logic        ack_c_q, ack_c_d;
  logic        ack_s_q, ack_s_d;
  logic        busy_q, busy_d;
  logic        abort;

  req_id_e     gnt_id;
  logic        gnt_vld;

  dds_prio_enc u_prio (
    .req_sweep  (req_sweep),
    .req_config (req_config),
    .req_update (req_update),
    .gnt_id     (gnt_id),
    .gnt_vld    (gnt_vld)
  );

  // Next-state logic; all outputs are derived from the next state so they
  // come straight out of flops.
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    cnt_d   = cnt_q;
    step_d  = step_q;
    err_d   = err_q;
    abort   = 1'b0;

    case (state_q)
      IDLE: begin
        if (gnt_vld && !dds_busy) begin
          state_d = WAIT_HI;
          id_d    = gnt_id;
          cnt_d   = 16'd0;
          if (gnt_id == ID_CONFIG) step_d = cfg_step;
        end
      end
      WAIT_HI: begin
        cnt_d = cnt_q + 16'd1;
        if (dds_busy)                state_d = WAIT_LO;
        else if (cnt_q == TO_LAST)   abort   = 1'b1;
      end
      WAIT_LO: begin
        cnt_d = cnt_q + 16'd1;
        if (!dds_busy)               state_d = ACK;
        else if (cnt_q == TO_LAST)   abort   = 1'b1;
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (abort) state_d = ACK;

    // A timeout on the same edge as a clear leaves the flag set.
    if (clr_err) err_d = 1'b0;
    if (abort)   err_d = 1'b1;

    upd_d   = (state_d == WAIT_HI) && (id_d == ID_UPDATE);
    cfg_d   = (state_d == WAIT_HI) && (id_d == ID_CONFIG);
    swp_d   = (state_d == WAIT_HI) && (id_d == ID_SWEEP);
    ack_u_d = (state_d == ACK)     && (id_d == ID_UPDATE);
    ack_c_d = (state_d == ACK)     && (id_d == ID_CONFIG);
    ack_s_d = (state_d == ACK)     && (id_d == ID_SWEEP);
    busy_d  = (state_d != IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      id_q    <= ID_UPDATE;
      cnt_q   <= 16'd0;
      step_q  <= STEP_RESET;
      err_q   <= 1'b0;
      upd_q   <= 1'b0;
      cfg_q   <= 1'b0;
      swp_q   <= 1'b0;
      ack_u_q <= 1'b0;
      ack_c_q <= 1'b0;
      ack_s_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
      step_q  <= step_d;
      err_q   <= err_d;
      upd_q   <= upd_d;
      cfg_q   <= cfg_d;
      swp_q   <= swp_d;
      ack_u_q <= ack_u_d;
      ack_c_q <= ack_c_d;
      ack_s_q <= ack_s_d;
      busy_q  <= busy_d;
    end
  end

  assign dds_update        = upd_q;
  assign dds_update_config = cfg_q;
  assign dds_sweep         = swp_q;
  assign ack_update        = ack_u_q;
  assign ack_config        = ack_c_q;
  assign ack_sweep         = ack_s_q;
  assign dds_sweep_step    = step_q;
  assign arb_busy          = busy_q;
  assign timeout_err       = err_q;

endmodule

// File: tb/tb_dds_cmd_arbiter.sv
// Scoreboard bench for dds_cmd_arbiter: stimulus pushes expected acks,
// a negedge monitor pops and compares them and checks strobe/ack exclusivity.
module tb_dds_cmd_arbiter;

  logic        clk = 1'b0;
  logic        rst, req_update, req_config, req_sweep, dds_busy, clr_err;
  logic [31:0] cfg_step;
  logic        ack_update, ack_config, ack_sweep;
  logic        dds_update, dds_update_config, dds_sweep;
  logic [31:0] dds_sweep_step;
  logic        arb_busy, timeout_err;

  dds_cmd_arbiter #(.TIMEOUT_CYCLES(16), .STEP_RESET(32'h00221b26)) dut (
    .clk               (clk),
    .rst               (rst),
    .req_update        (req_update),
    .req_config        (req_config),
    .cfg_step          (cfg_step),
    .req_sweep         (req_sweep),
    .ack_update        (ack_update),
    .ack_config        (ack_config),
    .ack_sweep         (ack_sweep),
    .dds_update        (dds_update),
    .dds_update_config (dds_update_config),
    .dds_sweep         (dds_sweep),
    .dds_sweep_step    (dds_sweep_step),
    .dds_busy          (dds_busy),
    .arb_busy          (arb_busy),
    .timeout_err       (timeout_err),
    .clr_err           (clr_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  ack;   // {sweep, config, update}
    logic        err;
    logic [31:0] step;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  int   cyc = 0, rc = 0, busy_len = 10, fall_cyc = 0, ack_cyc = 0;
  bit   auto_en = 1'b0, drop_u = 1'b0, drop_c = 1'b0, drop_s = 1'b0;

  // Monitor: exclusivity every cycle, scoreboard compare on every ack.
  always @(negedge clk) begin
    logic [2:0] acks;
    logic [2:0] strb;
    exp_t       e;
    acks = {ack_sweep, ack_config, ack_update};
    strb = {dds_sweep, dds_update_config, dds_update};
    n_checks++;
    if (!rst && (($countones(strb) > 1) || (strb != 3'b000 && acks != 3'b000))) begin
      n_errors++;
      $display("FAIL exclusivity: strobes=%b acks=%b, required at most one strobe and none with an ack", strb, acks);
    end
    if (acks != 3'b000) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL unexpected_ack: got acks=%b, required none", acks);
      end else begin
        e = exp_q.pop_front();
        if (acks !== e.ack || timeout_err !== e.err || dds_sweep_step !== e.step) begin
          n_errors++;
          $display("FAIL ack_compare: got acks=%b err=%b step=%h, required acks=%b err=%b step=%h",
                   acks, timeout_err, dds_sweep_step, e.ack, e.err, e.step);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got %h, required %h", name, act, expv);
    end
  endtask

  task automatic push(input logic [2:0] ack, input logic err, input logic [31:0] step);
    exp_t e;
    e.ack  = ack;
    e.err  = err;
    e.step = step;
    exp_q.push_back(e);
  endtask

  // One clock: requesters drop req the edge after their ack; driver model
  // raises busy 3 cycles after seeing a strobe and holds it busy_len cycles.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (drop_u) req_update = 1'b0;
    if (drop_c) req_config = 1'b0;
    if (drop_s) req_sweep  = 1'b0;
    drop_u = ack_update;
    drop_c = ack_config;
    drop_s = ack_sweep;
    if (auto_en) begin
      if (rc == 0) begin
        if (dds_update || dds_update_config || dds_sweep) rc = 1;
      end else begin
        rc++;
        if (rc == 3) dds_busy = 1'b1;
        else if (rc == 3 + busy_len) begin
          dds_busy = 1'b0;
          rc       = 0;
          fall_cyc = cyc;
        end
      end
    end
  endtask

  task automatic wait_ack(input string name);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while ({ack_sweep, ack_config, ack_update} == 3'b000 && n < 100);
    ack_cyc = cyc;
    n_checks++;
    if ({ack_sweep, ack_config, ack_update} == 3'b000) begin
      n_errors++;
      $display("FAIL %s_wait: no ack within 100 cycles, required an ack", name);
    end
  endtask

  initial begin
    int n;
    int hits;
    rst = 1'b1; req_update = 1'b0; req_config = 1'b0; req_sweep = 1'b0;
    dds_busy = 1'b0; clr_err = 1'b0; cfg_step = 32'h0;
    tick(); tick();
    chk("reset_outputs", 32'({dds_update, dds_update_config, dds_sweep, ack_update,
                              ack_config, ack_sweep, arb_busy, timeout_err}), 32'h0);
    chk("reset_step", dds_sweep_step, 32'h00221b26);
    rst = 1'b0;
    tick();

    // Plain update with a responsive driver.
    auto_en = 1'b1; busy_len = 10;
    push(3'b001, 1'b0, 32'h00221b26);
    req_update = 1'b1;
    tick();
    chk("upd_strobe_latency", 32'(dds_update), 32'd1);
    chk("upd_step", dds_sweep_step, 32'h00221b26);
    n = 1;
    do begin tick(); n++; end while (dds_update && n < 20);
    chk("upd_strobe_len", 32'(n - 1), 32'd3);
    wait_ack("update");
    chk("ack_after_busy_fall", 32'(ack_cyc - fall_cyc), 32'd1);
    tick();
    chk("ack_one_cycle", 32'(ack_update), 32'd0);

    // Config: step loaded at the grant edge only.
    cfg_step = 32'h0006d23a;
    push(3'b010, 1'b0, 32'h0006d23a);
    req_config = 1'b1;
    tick();
    chk("cfg_strobe", 32'(dds_update_config), 32'd1);
    chk("cfg_step_at_grant", dds_sweep_step, 32'h0006d23a);
    cfg_step = 32'hdeadbeef;
    wait_ack("config");
    tick(); tick();
    chk("cfg_step_holds", dds_sweep_step, 32'h0006d23a);

    // Simultaneous requests: sweep, then config, then update.
    cfg_step = 32'h12345678;
    push(3'b100, 1'b0, 32'h0006d23a);
    push(3'b010, 1'b0, 32'h12345678);
    push(3'b001, 1'b0, 32'h12345678);
    req_sweep = 1'b1; req_config = 1'b1; req_update = 1'b1;
    wait_ack("prio_1");
    wait_ack("prio_2");
    wait_ack("prio_3");
    tick(); tick();

    // Driver never answers: abort after 16 cycles in WAIT_HI.
    auto_en = 1'b0; dds_busy = 1'b0;
    push(3'b100, 1'b1, 32'h12345678);
    req_sweep = 1'b1;
    tick();
    n = 1;
    do begin tick(); n++; end while (dds_sweep && n < 40);
    chk("timeout_strobe_len", 32'(n - 1), 32'd16);
    chk("timeout_err_set", 32'(timeout_err), 32'd1);
    chk("timeout_ack", 32'(ack_sweep), 32'd1);
    tick();
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("clr_err_clears", 32'(timeout_err), 32'd0);

    // Clear held across a second abort: set wins.
    push(3'b100, 1'b1, 32'h12345678);
    req_sweep = 1'b1; clr_err = 1'b1;
    wait_ack("timeout_2");
    clr_err = 1'b0;
    tick();
    chk("err_set_wins", 32'(timeout_err), 32'd1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("clr_err_again", 32'(timeout_err), 32'd0);

    // Driver busy while idle: request must wait.
    tick();
    dds_busy = 1'b1;
    push(3'b001, 1'b0, 32'h12345678);
    req_update = 1'b1;
    hits = 0;
    repeat (5) begin
      tick();
      if (dds_update || arb_busy) hits++;
    end
    chk("no_grant_while_busy", 32'(hits), 32'd0);
    auto_en = 1'b1; rc = 0; dds_busy = 1'b0;
    tick();
    chk("grant_after_busy_fall", 32'(dds_update), 32'd1);
    wait_ack("busy_idle");
    tick(); tick();

    // Reset while in WAIT_LO: everything clears, no ack.
    req_update = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!(dds_busy && arb_busy && !dds_update) && n < 30);
    chk("reached_wait_lo", 32'(n < 30), 32'd1);
    rst = 1'b1;
    tick();
    chk("midrst_outputs", 32'({dds_update, dds_update_config, dds_sweep, ack_update,
                               ack_config, ack_sweep, arb_busy, timeout_err}), 32'h0);
    chk("midrst_step", dds_sweep_step, 32'h00221b26);
    rst = 1'b0; req_update = 1'b0; auto_en = 1'b0; rc = 0; dds_busy = 1'b0;
    drop_u = 1'b0; drop_c = 1'b0; drop_s = 1'b0;
    repeat (5) tick();
    chk("midrst_idle", 32'(arb_busy), 32'd0);

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
